sec_ded_scrub_ctrl: RTL and testbench

Read-path stage directly downstream of the SEC-DED Hsiao decoder (DW=11, 5 check bits). Registers each decoded read word with its status and forwards it to the consumer over a valid/ready handshake. Issues a write-back (scrub) of corrected data plus regenerated check bits to the memory port on every single-bit error. Keeps saturating error counters and logs the address of the most recent double-bit error.

---
 rtl/sec_ded_scrub_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sec_ded_scrub_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sec_ded_scrub_ctrl.sv
// ============================================================================
// Module   : sec_ded_scrub_ctrl
// Purpose  : Registers decoded read words, forwards them over valid/ready, and
//            scrubs single-bit errors back to memory while keeping error stats.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sec_ded_scrub_ctrl #(
  parameter int DW   = 11,
  parameter int CW   = 5,
  parameter int AW   = 10,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_valid,
  output logic            rd_ready,
  input  logic [AW-1:0]   rd_addr,
  input  logic [DW-1:0]   dec_data,
  input  logic [CW-1:0]   dec_check,
  input  logic            dec_sec,
  input  logic            dec_ded,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_sec,
  output logic            out_ded,
  output logic            wb_req,
  input  logic            wb_gnt,
  output logic [AW-1:0]   wb_addr,
  output logic [DW-1:0]   wb_data,
  output logic [CW-1:0]   wb_check,
  output logic [CNTW-1:0] sec_cnt,
  output logic [CNTW-1:0] ded_cnt,
  output logic [AW-1:0]   ded_addr,
  output logic            ded_seen,
  input  logic            clr_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OUT    = 2'd1,
    OUT_WB = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [CNTW-1:0] c_cnt_max = '1;
  localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_next;
  logic            r_live;
  logic [DW-1:0]   r_out_data;
  logic            r_out_sec;
  logic            r_out_ded;
  logic [AW-1:0]   r_wb_addr;
  logic [DW-1:0]   r_wb_data;
  logic [CW-1:0]   r_wb_check;
  logic [CNTW-1:0] r_sec_cnt;
  logic [CNTW-1:0] r_ded_cnt;
  logic [AW-1:0]   r_ded_addr;
  logic            r_ded_seen;

  logic w_accept;
  logic w_sec;
  logic w_ded;
  logic w_out_done;
  logic w_wb_done;

  // A word flagged both SEC and DED is uncorrectable, so DED dominates.
  assign w_ded      = dec_ded;
  assign w_sec      = dec_sec && !dec_ded;
  assign w_accept   = rd_valid && rd_ready;
  assign w_out_done = out_valid && out_ready;
  assign w_wb_done  = wb_req && wb_gnt;

  // r_live keeps rd_ready low while reset is held without using rst_n as data.
  assign rd_ready  = r_live && (r_state == IDLE);
  assign out_valid = (r_state == OUT) || (r_state == OUT_WB);
  assign wb_req    = (r_state == OUT_WB) || (r_state == WB);

  assign out_data  = r_out_data;
  assign out_sec   = r_out_sec;
  assign out_ded   = r_out_ded;
  assign wb_addr   = wb_req ? r_wb_addr  : '0;
  assign wb_data   = wb_req ? r_wb_data  : '0;
  assign wb_check  = wb_req ? r_wb_check : '0;
  assign sec_cnt   = r_sec_cnt;
  assign ded_cnt   = r_ded_cnt;
  assign ded_addr  = r_ded_addr;
  assign ded_seen  = r_ded_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_accept) w_next = w_sec ? OUT_WB : OUT;
      OUT:    if (out_ready) w_next = IDLE;
      OUT_WB: begin
        case ({out_ready, wb_gnt})
          2'b11:   w_next = IDLE;
          2'b10:   w_next = WB;
          2'b01:   w_next = OUT;
          default: w_next = OUT_WB;
        endcase
      end
      WB:     if (wb_gnt) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output and scrub payloads live separately: the scrub may outlast the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_sec  <= 1'b0;
      r_out_ded  <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_wb_check <= '0;
    end else begin
      if (w_accept) begin
        r_out_data <= dec_data;
        r_out_sec  <= w_sec;
        r_out_ded  <= w_ded;
      end else if (w_out_done) begin
        r_out_data <= '0;
        r_out_sec  <= 1'b0;
        r_out_ded  <= 1'b0;
      end
      if (w_accept && w_sec) begin
        r_wb_addr  <= rd_addr;
        r_wb_data  <= dec_data;
        r_wb_check <= dec_check;
      end else if (w_wb_done) begin
        r_wb_addr  <= '0;
        r_wb_data  <= '0;
        r_wb_check <= '0;
      end
    end
  end

  // A new error event in the clear cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_cnt  <= '0;
      r_ded_cnt  <= '0;
      r_ded_addr <= '0;
      r_ded_seen <= 1'b0;
    end else begin
      if (w_accept && w_sec) begin
        if (clr_err)                     r_sec_cnt <= c_cnt_one;
        else if (r_sec_cnt != c_cnt_max) r_sec_cnt <= r_sec_cnt + c_cnt_one;
      end else if (clr_err) begin
        r_sec_cnt <= '0;
      end
      if (w_accept && w_ded) begin
        if (clr_err)                     r_ded_cnt <= c_cnt_one;
        else if (r_ded_cnt != c_cnt_max) r_ded_cnt <= r_ded_cnt + c_cnt_one;
        r_ded_addr <= rd_addr;
        r_ded_seen <= 1'b1;
      end else if (clr_err) begin
        r_ded_cnt  <= '0;
        r_ded_seen <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sec_ded_scrub_ctrl.sv
// ============================================================================
// Module   : tb_sec_ded_scrub_ctrl
// Purpose  : Scoreboard bench for sec_ded_scrub_ctrl (output and scrub queues).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sec_ded_scrub_ctrl;

  localparam int DW = 11, CW = 5, AW = 10, CNTW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rd_valid = 1'b0;
  logic            rd_ready;
  logic [AW-1:0]   rd_addr = '0;
  logic [DW-1:0]   dec_data = '0;
  logic [CW-1:0]   dec_check = '0;
  logic            dec_sec = 1'b0;
  logic            dec_ded = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   out_data;
  logic            out_sec;
  logic            out_ded;
  logic            wb_req;
  logic            wb_gnt = 1'b1;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic [CW-1:0]   wb_check;
  logic [CNTW-1:0] sec_cnt;
  logic [CNTW-1:0] ded_cnt;
  logic [AW-1:0]   ded_addr;
  logic            ded_seen;
  logic            clr_err = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] out_q[$];
  logic [31:0] wb_q[$];
  int m_sec = 0, m_ded = 0, m_seen = 0, m_daddr = 0;

  always #5 clk = ~clk;

  sec_ded_scrub_ctrl #(.DW(DW), .CW(CW), .AW(AW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr(rd_addr), .dec_data(dec_data), .dec_check(dec_check),
    .dec_sec(dec_sec), .dec_ded(dec_ded), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sec(out_sec),
    .out_ded(out_ded), .wb_req(wb_req), .wb_gnt(wb_gnt), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_check(wb_check), .sec_cnt(sec_cnt),
    .ded_cnt(ded_cnt), .ded_addr(ded_addr), .ded_seen(ded_seen),
    .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes popped against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) check("out_unexpected", 32'd1, 32'd0);
        else check("out_word", {19'd0, out_ded, out_sec, out_data}, out_q.pop_front());
      end
      if (wb_req && wb_gnt) begin
        if (wb_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
        else check("wb_word", {6'd0, wb_addr, wb_check, wb_data}, wb_q.pop_front());
      end
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input logic s, input logic e);
    int n = 0;
    logic ms, me;
    rd_valid = 1'b1; rd_addr = a; dec_data = d; dec_check = c; dec_sec = s; dec_ded = e;
    while (!rd_ready && n < 100) begin tick(); n++; end
    if (!rd_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    me = e;
    ms = s && !e;
    out_q.push_back({19'd0, me, ms, d});
    if (ms) wb_q.push_back({6'd0, a, c, d});
    if (ms) m_sec = clr_err ? 1 : (m_sec < 255 ? m_sec + 1 : 255);
    else if (clr_err) m_sec = 0;
    if (me) begin
      m_ded = clr_err ? 1 : (m_ded < 255 ? m_ded + 1 : 255);
      m_seen = 1; m_daddr = a;
    end else if (clr_err) begin
      m_ded = 0; m_seen = 0;
    end
    #1;
    rd_valid = 1'b0; dec_sec = 1'b0; dec_ded = 1'b0; clr_err = 1'b0;
    if (!out_valid) check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    if (wb_req !== ms) check("latency_wb_req", {31'd0, wb_req}, {31'd0, ms});
  endtask

  task automatic drain();
    int n = 0;
    while ((!rd_ready || out_q.size() != 0 || wb_q.size() != 0) && n < 100) begin tick(); n++; end
    check("drain_done", {31'd0, rd_ready && out_q.size() == 0 && wb_q.size() == 0}, 32'd1);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_sec_cnt"}, {24'd0, sec_cnt}, m_sec);
    check({tag, "_ded_cnt"}, {24'd0, ded_cnt}, m_ded);
    check({tag, "_ded_seen"}, {31'd0, ded_seen}, m_seen);
    check({tag, "_ded_addr"}, {22'd0, ded_addr}, m_daddr);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_wb_req", {31'd0, wb_req}, 32'd0);
    check_stats("rst");
    @(posedge clk); #1; rst_n = 1'b1;
    tick();
    check("rel_rd_ready", {31'd0, rd_ready}, 32'd1);

    // Clean word
    send(10'h005, 11'h7ff, 5'h1f, 1'b0, 1'b0);
    check("clean_no_wb", {31'd0, wb_req}, 32'd0);
    tick();
    check("clean_rd_ready_n2", {31'd0, rd_ready}, 32'd1);
    check("clean_out_zeroed", {20'd0, out_valid, out_data}, 32'd0);
    check_stats("clean");

    // Single error, grant withheld three cycles
    wb_gnt = 1'b0;
    send(10'h010, 11'h7ff, 5'h1f, 1'b1, 1'b0);
    check("sec_cnt_1", {24'd0, sec_cnt}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wb_state_out_valid", {31'd0, out_valid}, 32'd0);
      check("wb_hold", {5'd0, wb_req, wb_addr, wb_check, wb_data}, {5'd0, 1'b1, 10'h010, 5'h1f, 11'h7ff});
    end
    wb_gnt = 1'b1;
    tick();
    check("wb_released", {5'd0, wb_req, wb_addr, wb_check, wb_data}, 32'd0);
    drain();

    // Double error
    send(10'h3a0, 11'h7ef, 5'h03, 1'b0, 1'b1);
    check("ded_out", {30'd0, out_ded, out_sec}, 32'd2);
    check("ded_no_wb", {31'd0, wb_req}, 32'd0);
    drain();
    check_stats("ded");

    // Both flags: DED only
    send(10'h123, 11'h555, 5'h0a, 1'b1, 1'b1);
    check("both_no_wb", {31'd0, wb_req}, 32'd0);
    drain();
    check_stats("both");

    // Scrub granted before the consumer takes the word
    out_ready = 1'b0;
    send(10'h0ff, 11'h2aa, 5'h15, 1'b1, 1'b0);
    tick();
    check("gnt_first_out", {30'd0, out_valid, wb_req}, 32'd2);
    out_ready = 1'b1;
    drain();

    // Saturation of the SEC counter
    for (int i = 0; i < 260; i++) begin
      send(AW'($urandom_range(0, 1023)), DW'($urandom), CW'($urandom), 1'b1, 1'b0);
      drain();
    end
    check("sec_saturated", {24'd0, sec_cnt}, 32'hff);
    check_stats("sat");

    // Clear coinciding with a SEC accept, then a bare clear
    clr_err = 1'b1;
    send(10'h001, 11'h001, 5'h01, 1'b1, 1'b0);
    drain();
    check_stats("clr_sec");
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    m_sec = 0; m_ded = 0; m_seen = 0;
    check_stats("clr_alone");

    // Clear coinciding with a DED accept
    clr_err = 1'b1;
    send(10'h2c4, 11'h0f0, 5'h02, 1'b0, 1'b1);
    drain();
    check_stats("clr_ded");

    // Reset while in OUT_WB
    out_ready = 1'b0; wb_gnt = 1'b0;
    send(10'h077, 11'h321, 5'h07, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", {29'd0, out_valid, wb_req, rd_ready}, 32'd0);
    check("midrst_cnts", {15'd0, ded_seen, ded_cnt, sec_cnt}, 32'd0);
    out_q.delete(); wb_q.delete();
    m_sec = 0; m_ded = 0; m_seen = 0; m_daddr = 0;
    out_ready = 1'b1; wb_gnt = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    tick();
    check("midrst_rd_ready", {31'd0, rd_ready}, 32'd1);
    send(10'h005, 11'h7ff, 5'h1f, 1'b0, 1'b0);
    drain();
    check_stats("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
